// File: rtl/l1b_pkg.sv
// l1b_pkg: shared sequencer state type and default timing constants for the L1B CPLD.
// Rev 1.0
`default_nettype none

package l1b_pkg;

  typedef enum logic [1:0] {
    ST_FAST_LO = 2'd0,
    ST_FAST_HI = 2'd1,
    ST_SYNC    = 2'd2,
    ST_HOST_HI = 2'd3
  } seq_state_t;

  localparam int L1B_FAST_LO     = 2;
  localparam int L1B_FAST_HI     = 2;
  localparam int L1B_SYNC_STAGES = 2;

  // Phase counter width; at least one bit even when both phases are a single cycle.
  function automatic int phase_cnt_width(input int lo, input int hi);
    int longest;
    longest = (lo > hi) ? lo : hi;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

`default_nettype wire

// File: rtl/host_cycle_sequencer_phi0_sync.sv
// phi0_sync: synchroniser for the host phi0 plus registered-history edge detection.
// Rev 1.0
`default_nettype none

module phi0_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic hsclk,
  input  logic reset,
  input  logic phi0_async,
  output logic s_phi0,
  output logic phi0_rise,
  output logic phi0_fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge hsclk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], phi0_async};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign s_phi0    = chain[SYNC_STAGES-1];
  assign phi0_rise = s_phi0 & ~prev;
  assign phi0_fall = ~s_phi0 & prev;

endmodule

`default_nettype wire

// File: rtl/host_cycle_sequencer.sv
// host_cycle_sequencer: 65816 phi2 generator that stretches host cycles onto BBC phi0-high.
// Rev 1.0 -- optional write posting enabled by defining L1B_WRITE_POST_EN.
`default_nettype none

module host_cycle_sequencer
  import l1b_pkg::*;
#(
  parameter int FAST_LO     = L1B_FAST_LO,
  parameter int FAST_HI     = L1B_FAST_HI,
  parameter int SYNC_STAGES = L1B_SYNC_STAGES
) (
  input  logic hsclk,
  input  logic reset,
  input  logic bbc_phi0,
  input  logic cpu_valid,
  input  logic host_sel,
  input  logic cpu_rnw,
  output logic cpu_phi2,
  output logic bbc_cycle,
  output logic host_data_le,
  output logic post_le,
  output logic busy
);

  localparam int            CW      = phase_cnt_width(FAST_LO, FAST_HI);
  localparam logic [CW-1:0] LO_LAST = CW'(FAST_LO - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(FAST_HI - 1);

`ifdef L1B_WRITE_POST_EN
  localparam logic POST_EN = 1'b1;
`else
  localparam logic POST_EN = 1'b0;
`endif

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          s_phi0, phi0_rise, phi0_fall;
  logic          post_ok, post_take, le_n;
  logic          post_pending, post_pending_n, post_active_n;

  phi0_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_phi0_sync (
    .hsclk     (hsclk),
    .reset     (reset),
    .phi0_async(bbc_phi0),
    .s_phi0    (s_phi0),
    .phi0_rise (phi0_rise),
    .phi0_fall (phi0_fall)
  );

  assign post_ok = POST_EN & ~cpu_rnw & ~post_pending;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    post_take = 1'b0;
    le_n      = 1'b0;
    case (state)
      ST_FAST_LO: begin
        if (cnt != LO_LAST)                cnt_n = cnt + 1'b1;
        else if (!(cpu_valid && host_sel)) state_n = ST_FAST_HI;
        else if (post_ok) begin
          state_n   = ST_FAST_HI;
          post_take = 1'b1;
        end else                           state_n = ST_SYNC;
      end
      ST_FAST_HI: begin
        if (cnt != HI_LAST) cnt_n = cnt + 1'b1;
        else                state_n = ST_FAST_LO;
      end
      // A rise already in flight on entry is missed, so only a full host phase is used.
      ST_SYNC: begin
        if (phi0_rise && !post_pending) state_n = ST_HOST_HI;
      end
      ST_HOST_HI: begin
        if (!s_phi0) begin
          state_n = ST_FAST_LO;
          le_n    = cpu_rnw;
        end
      end
      default: state_n = ST_FAST_LO;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge hsclk) begin
    if (reset) begin
      state        <= ST_FAST_LO;
      cnt          <= '0;
      cpu_phi2     <= 1'b0;
      bbc_cycle    <= 1'b0;
      host_data_le <= 1'b0;
      post_le      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cpu_phi2     <= (state_n == ST_FAST_HI) || (state_n == ST_HOST_HI);
      bbc_cycle    <= (state_n == ST_HOST_HI) || post_active_n;
      host_data_le <= le_n;
      post_le      <= post_take;
      busy         <= post_pending_n || (state_n == ST_SYNC) || (state_n == ST_HOST_HI);
    end
  end

`ifdef L1B_WRITE_POST_EN
  logic post_active;

  // The posted write owns the first phi0 rise after it is accepted, independent of the CPU.
  always_comb begin
    post_pending_n = post_pending;
    post_active_n  = post_active;
    if (post_take) begin
      post_pending_n = 1'b1;
    end else if (post_pending && !post_active && phi0_rise) begin
      post_active_n = 1'b1;
    end else if (post_active && phi0_fall) begin
      post_active_n  = 1'b0;
      post_pending_n = 1'b0;
    end
  end

  always_ff @(posedge hsclk) begin
    if (reset) begin
      post_pending <= 1'b0;
      post_active  <= 1'b0;
    end else begin
      post_pending <= post_pending_n;
      post_active  <= post_active_n;
    end
  end
`else
  logic unused_fall;
  assign post_pending   = 1'b0;
  assign post_pending_n = 1'b0;
  assign post_active_n  = 1'b0;
  assign unused_fall    = phi0_fall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_host_cycle_sequencer.sv
// tb_host_cycle_sequencer: randomized bench; expected output toggle times are queued per signal.
// Rev 1.0
`default_nettype none

module tb_host_cycle_sequencer;

  localparam int FL   = 2;
  localparam int FH   = 2;
  localparam int S    = 2;
  localparam int WMAX = 6000;

  localparam int E_PHI2 = 0;
  localparam int E_BBC  = 1;
  localparam int E_LE   = 2;
  localparam int E_POST = 3;
  localparam int E_BUSY = 4;

`ifdef L1B_WRITE_POST_EN
  localparam bit POST_EN = 1'b1;
`else
  localparam bit POST_EN = 1'b0;
`endif

  logic hsclk = 1'b0;
  logic reset, bbc_phi0, cpu_valid, host_sel, cpu_rnw;
  logic cpu_phi2, bbc_cycle, host_data_le, post_le, busy;

  host_cycle_sequencer #(
    .FAST_LO    (FL),
    .FAST_HI    (FH),
    .SYNC_STAGES(S)
  ) dut (
    .hsclk       (hsclk),
    .reset       (reset),
    .bbc_phi0    (bbc_phi0),
    .cpu_valid   (cpu_valid),
    .host_sel    (host_sel),
    .cpu_rnw     (cpu_rnw),
    .cpu_phi2    (cpu_phi2),
    .bbc_cycle   (bbc_cycle),
    .host_data_le(host_data_le),
    .post_le     (post_le),
    .busy        (busy)
  );

  always #5 hsclk = ~hsclk;

  // edge_cnt == n between rising edge n and n+1; sample n is taken on that falling edge.
  int edge_cnt = 0;
  always @(posedge hsclk) edge_cnt <= edge_cnt + 1;

  logic       w [0:WMAX];
  int         rst_edge;
  int         post_f;
  int         busy_end;
  int         vectors     = 0;
  int         miscompares = 0;
  int         evq [5][$];
  logic [4:0] prev_out    = 5'b0;
  bit         mon_on      = 1'b0;

  // phi0 as the sequencer perceives it at edge m: delayed S edges, zero until flushed after reset.
  function automatic logic ph(input int m);
    if (m - S <= rst_edge) return 1'b0;
    return w[m-S];
  endfunction

  function automatic int next_rise(input int after);
    for (int m = after + 1; m < WMAX; m++)
      if (ph(m) && !ph(m-1)) return m;
    return WMAX;
  endfunction

  function automatic int next_fall(input int after);
    for (int m = after + 1; m < WMAX; m++)
      if (!ph(m) && ph(m-1)) return m;
    return WMAX;
  endfunction

  task automatic push_pulse(input int id, input int t_on, input int t_off);
    evq[id].push_back(t_on);
    evq[id].push_back(t_off);
  endtask

  // busy is the union of pending-post and stall windows; abutting windows merge.
  task automatic push_busy(input int t_on, input int t_off);
    if (t_on <= busy_end) void'(evq[E_BUSY].pop_back());
    else                  evq[E_BUSY].push_back(t_on);
    evq[E_BUSY].push_back(t_off);
    busy_end = t_off;
  endtask

  task automatic check_sig(input int id, input string name, input logic v, input int n);
    int t;
    while (evq[id].size() > 0 && evq[id][0] < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: expected toggle at cycle %0d missing, value %0b at cycle %0d",
               name, evq[id][0], v, n);
      void'(evq[id].pop_front());
    end
    if (v !== prev_out[id]) begin
      t = -1;
      if (evq[id].size() > 0) t = evq[id].pop_front();
      vectors++;
      if (t != n) begin
        miscompares++;
        $display("FAIL %s: toggled to %0b at cycle %0d, expected toggle at cycle %0d",
                 name, v, n, t);
      end
      prev_out[id] = v;
    end
  endtask

  always @(negedge hsclk) begin
    if (mon_on) begin
      check_sig(E_PHI2, "cpu_phi2",     cpu_phi2,     edge_cnt);
      check_sig(E_BBC,  "bbc_cycle",    bbc_cycle,    edge_cnt);
      check_sig(E_LE,   "host_data_le", host_data_le, edge_cnt);
      check_sig(E_POST, "post_le",      post_le,      edge_cnt);
      check_sig(E_BUSY, "busy",         busy,         edge_cnt);
    end
  end

  // Drive the inputs sampled by the next rising edge, then move to the next sample point.
  task automatic step(input logic r, input logic v, input logic s, input logic rw);
    reset     = r;
    cpu_valid = v;
    host_sel  = s;
    cpu_rnw   = rw;
    bbc_phi0  = w[edge_cnt+1];
    @(negedge hsclk);
  endtask

  initial begin
    int   idx, len, t0, d, m, f, t_next, rst_at;
    logic lvl, v, s, rw;

    idx = 0;
    lvl = 1'b0;
    while (idx <= WMAX) begin
      len = ($urandom_range(2, 0) == 0) ? 8 : int'($urandom_range(12, 3));
      for (int k = 0; k < len && idx <= WMAX; k++) begin
        w[idx] = lvl;
        idx++;
      end
      lvl = ~lvl;
    end
    w[1] = 1'b1;
    w[2] = 1'b0;
    w[3] = 1'b1;

    rst_edge = 3;
    post_f   = -1;
    busy_end = -1;
    mon_on   = 1'b1;

    for (int e = 1; e <= 3; e++)
      step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));

    vectors++;
    if ({cpu_phi2, bbc_cycle, host_data_le, post_le, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {cpu_phi2, bbc_cycle, host_data_le, post_le, busy});
    end

    t0 = 3;
    while (t0 < 4000) begin
      v      = ($urandom_range(3, 0) != 0);
      s      = 1'($urandom_range(1, 0));
      rw     = 1'($urandom_range(1, 0));
      d      = t0 + FL;
      rst_at = -1;
      if (!(v && s)) begin
        push_pulse(E_PHI2, d, d + FH);
        t_next = d + FH;
      end else if (POST_EN && !rw && d > post_f) begin
        m = next_rise(d);
        f = next_fall(m);
        push_pulse(E_POST, d, d + 1);
        push_pulse(E_BBC, m, f);
        push_busy(d, f);
        post_f = f;
        push_pulse(E_PHI2, d, d + FH);
        t_next = d + FH;
      end else begin
        m = next_rise((d > post_f) ? d : post_f);
        f = next_fall(m);
        if (f > m + 4 && $urandom_range(5, 0) == 0) begin
          rst_at = m + 4;
          f      = rst_at;
        end
        push_pulse(E_PHI2, m, f);
        push_pulse(E_BBC, m, f);
        push_busy(d, f);
        if (rw && rst_at < 0) push_pulse(E_LE, f, f + 1);
        t_next = f;
      end

      for (int e = t0 + 1; e <= t_next; e++) begin
        if (e == d) step(1'b0, v, s, rw);
        else        step(e == rst_at, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), rw);
      end

      if (rst_at >= 0) begin
        rst_edge = rst_at;
        post_f   = -1;
      end
      t0 = t_next;
    end

    step(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      while (evq[i].size() > 0) begin
        vectors++;
        miscompares++;
        $display("FAIL output_%0d: expected toggle at cycle %0d never seen", i, evq[i][0]);
        void'(evq[i].pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
